alu_seq_unit: RTL and testbench
===============================

Name: alu_seq_unit

Overview:
- Sequential handshake-driven execution unit: the responder side of the ALU operation interface (operands a, b plus 3-bit alucontrol in; result plus zero flag out).
- Accepts one operation per valid/ready handshake and returns a registered result with a tag.
- Logic/arithmetic ops complete in 1 cycle; shifts run on an iterative shifter.
- Sits between the pipeline issue logic (or a bus-attached test driver) and writeback; only one operation is in flight at a time.

Parameters:
WIDTH, 32, operand/result width in bits
SHIFT_STEP, 1, bits shifted per iteration cycle; power of 2, 1..WIDTH
TAG_W, 4, width of the pass-through transaction tag

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B; shift amount = b[$clog2(WIDTH)-1:0]
alucontrol  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
in_tag  in  TAG_W  request tag
out_valid  out  1  response valid
out_ready  in  1  consumer accepts response
result  out  WIDTH  operation result
zero  out  1  result == 0
out_tag  out  TAG_W  tag of the request that produced result
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; out_valid=0, result=0, zero=0, out_tag=0.
  - Internal accumulator and count are cleared.
  - Reset asserted mid-shift aborts the operation; no response is ever produced for it.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Combinational; never depends on in_valid.
- Accept = in_valid && in_ready at a rising edge. Operands, opcode and tag are sampled only at accept.
- Response hold: while out_valid && !out_ready, result, zero and out_tag stay stable and no new request is accepted.
- Response drain: out_valid falls on the edge where out_ready=1, unless a new result is loaded on that same edge, in which case out_valid stays 1 with the new data.
- States: IDLE, SHIFT.
- IDLE, accept of a non-shift op (000–101):
  - result <= f(a,b); zero <= (f==0); out_tag <= in_tag; out_valid <= 1.
  - Latency 1 cycle; back-to-back throughput 1 op/cycle when out_ready=1.
- IDLE, accept of sll/srl:
  - acc <= a; cnt <= shamt; tag latched; state -> SHIFT.
- SHIFT, cnt != 0:
  - step = min(cnt, SHIFT_STEP).
  - acc <= acc << step (sll) or acc >> step (srl, zero fill).
  - cnt <= cnt - step.
- SHIFT, cnt == 0:
  - result <= acc; zero <= (acc==0); out_tag <= latched tag; out_valid <= 1; state -> IDLE.
- Shift latency = ceil(shamt/SHIFT_STEP) + 1 cycles from accept to out_valid.
  - shamt=0 gives latency 1 and result=a.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH; no carry/overflow output.
  - slt is signed two's complement; result = {WIDTH-1 zeros, a<b}.
  - Bits of b above shamt are ignored for shifts.
- in_valid deasserted with in_ready=1: no state change.
- Inputs changing while the unit is not ready have no effect.

Test Plan:
- Reset then add: a=5, b=3, op=000, out_ready=1 -> one cycle later out_valid=1, result=0x8, zero=0, out_tag=in_tag.
- Back-to-back single-cycle ops:
  - Stimulus: sub 8-3, and FFFFFFFF&0F0F0F0F, or AAAAAAAA|55555555, xor 12345678^87654321, slt 1<2, sub 2-2 on consecutive cycles, out_ready=1.
  - Response, one per cycle: 0x5, 0x0F0F0F0F, 0xFFFFFFFF, 0x95511559, 0x1, 0x0 with zero=1.
- slt signed: a=0xFFFFFFFF, b=1 -> result=1; a=1, b=0xFFFFFFFF -> result=0.
- Shifts, SHIFT_STEP=1:
  - sll a=1, b=4 -> in_ready=0 and busy=1 for 5 cycles, then result=0x10 (latency 5).
  - srl a=0x10, b=2 -> result=0x4, latency 3.
  - sll with b=0x20 -> shamt=0, result=a, latency 1.
- Backpressure: out_ready=0 for 4 cycles after add result -> result/tag stable, in_ready=0, second request held. Raise out_ready -> first drained, second accepted same edge, its result appears next cycle.
- Reset mid-shift: srl a=0xFFFFFFFF, b=31; assert reset_n=0 at cycle 10 -> out_valid=0, busy=0 immediately. After release, add 1+1 returns 0x2 with no stale shift response.

Source files
------------

// File: rtl/alu_seq_if.sv
// ALU operation handshake bundle.
// Request carries operands, opcode and tag; response returns result, zero flag and tag.
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alucontrol;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a, b, alucontrol, in_tag,
    output out_ready,
    input  in_ready, out_valid, result, zero, out_tag
  );

  modport slave (
    input  in_valid, a, b, alucontrol, in_tag,
    input  out_ready,
    output in_ready, out_valid, result, zero, out_tag
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshake-driven ALU: single-cycle logic/arith ops.
// Shifts run on an iterative shifter, SHIFT_STEP bits per cycle.
module alu_seq_unit #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1,
  parameter int TAG_W      = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  alu_seq_if.slave bus,
  output logic   busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW:0] STEP = (CW+1)'(SHIFT_STEP);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             dir_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic [TAG_W-1:0] otag_q;
  logic             ovalid_q;

  logic             rdy;
  logic             accept;
  logic             is_shift;
  logic             done;
  logic [CW:0]      step;
  logic [WIDTH-1:0] acc_sh;
  logic [WIDTH-1:0] alu_res;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept && is_shift) state_d = SHIFT;
      SHIFT: if (cnt_q == '0)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    rdy  = (state_q == IDLE) &&
           (!ovalid_q || bus.out_ready);
  end

  assign accept   = bus.in_valid && rdy;
  assign is_shift = (bus.alucontrol[2:1] == 2'b11);
  assign done     = (state_q == SHIFT) && (cnt_q == '0);

  always_comb begin
    alu_res = '0;
    case (bus.alucontrol)
      3'b000: alu_res = bus.a + bus.b;
      3'b001: alu_res = bus.a - bus.b;
      3'b010: alu_res = bus.a & bus.b;
      3'b011: alu_res = bus.a | bus.b;
      3'b100: alu_res = bus.a ^ bus.b;
      3'b101: alu_res = {{(WIDTH-1){1'b0}},
                ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

  // Last iteration may move fewer than SHIFT_STEP bits.
  always_comb begin
    if ({1'b0, cnt_q} < STEP) step = {1'b0, cnt_q};
    else                      step = STEP;
    acc_sh = dir_q ? (acc_q >> step) : (acc_q << step);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      tag_q    <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      otag_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      if (accept && is_shift) begin
        acc_q <= bus.a;
        cnt_q <= bus.b[CW-1:0];
        dir_q <= bus.alucontrol[0];
        tag_q <= bus.in_tag;
      end else if (state_q == SHIFT &&
                   cnt_q != '0) begin
        acc_q <= acc_sh;
        cnt_q <= cnt_q - CW'(step);
      end
      if (accept && !is_shift) begin
        res_q    <= alu_res;
        zero_q   <= (alu_res == '0);
        otag_q   <= bus.in_tag;
        ovalid_q <= 1'b1;
      end else if (done) begin
        res_q    <= acc_q;
        zero_q   <= (acc_q == '0);
        otag_q   <= tag_q;
        ovalid_q <= 1'b1;
      end else if (bus.out_ready) begin
        ovalid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ovalid_q;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.out_tag   = otag_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit with a response scoreboard.
// Expected responses are queued at issue and popped on each transfer.
module tb_alu_seq_unit;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32), .TAG_W(4)) bus ();

  alu_seq_unit #(
    .WIDTH(32),
    .SHIFT_STEP(1),
    .TAG_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .busy(busy)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             name, obs, exp);
    end
  endtask

  // Transfer happens at the next posedge when
  // out_valid && out_ready hold at the negedge.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      chk("resp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("result", bus.result, mon_e.res);
        chk("zero", 32'(bus.zero), 32'(mon_e.z));
        chk("out_tag", 32'(bus.out_tag), 32'(mon_e.tag));
      end
    end
  end

  task automatic drive(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [3:0] tag,
                       input bit push,
                       input logic [31:0] er);
    exp_t e;
    e.res = er;
    e.z   = (er == 32'h0);
    e.tag = tag;
    if (push) exp_q.push_back(e);
    bus.in_valid   = 1'b1;
    bus.alucontrol = op;
    bus.a          = a;
    bus.b          = b;
    bus.in_tag     = tag;
  endtask

  task automatic send(input logic [2:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [3:0] tag,
                      input bit push,
                      input logic [31:0] er);
    int n;
    drive(op, a, b, tag, push, er);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 32'(n < 100), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Edges from the accept edge to the load edge.
  task automatic wait_lat(input string name,
                          input int exp_lat,
                          input int exp_busy);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      if (busy && !bus.in_ready) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk(name, lat, exp_lat);
    chk({name, "_busy"}, bcnt, exp_busy);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.alucontrol = '0;
    bus.in_tag     = '0;
    bus.out_ready  = 1'b1;
    idle(3);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", 32'(bus.zero), 0);
    chk("rst_out_tag", 32'(bus.out_tag), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    idle(1);
    chk("idle_in_ready", 32'(bus.in_ready), 1);

    send(3'b000, 32'd5, 32'd3, 4'h1, 1, 32'h8);
    @(negedge clk);
    chk("add_valid_next", 32'(bus.out_valid), 1);
    idle(2);

    send(3'b001, 32'd8, 32'd3, 4'h2, 1, 32'h5);
    c0 = cyc;
    send(3'b010, 32'hFFFFFFFF, 32'h0F0F0F0F,
         4'h3, 1, 32'h0F0F0F0F);
    send(3'b011, 32'hAAAAAAAA, 32'h55555555,
         4'h4, 1, 32'hFFFFFFFF);
    send(3'b100, 32'h12345678, 32'h87654321,
         4'h5, 1, 32'h95511559);
    send(3'b101, 32'd1, 32'd2, 4'h6, 1, 32'h1);
    send(3'b001, 32'd2, 32'd2, 4'h7, 1, 32'h0);
    chk("b2b_cycles", cyc - c0, 5);
    idle(3);

    send(3'b101, 32'hFFFFFFFF, 32'd1, 4'h8, 1, 32'h1);
    send(3'b101, 32'd1, 32'hFFFFFFFF, 4'h9, 1, 32'h0);
    idle(3);

    send(3'b110, 32'd1, 32'd4, 4'hA, 1, 32'h10);
    wait_lat("sll4_lat", 5, 5);
    idle(2);
    send(3'b111, 32'h10, 32'd2, 4'hB, 1, 32'h4);
    wait_lat("srl2_lat", 3, 3);
    idle(2);
    send(3'b110, 32'hDEADBEEF, 32'h20, 4'hC, 1,
         32'hDEADBEEF);
    wait_lat("sll0_lat", 1, 1);
    idle(2);

    bus.out_ready = 1'b0;
    send(3'b000, 32'd10, 32'd20, 4'h3, 1, 32'd30);
    drive(3'b001, 32'd100, 32'd1, 4'h4, 1, 32'd99);
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_result", bus.result, 32'd30);
      chk("bp_tag", 32'(bus.out_tag), 3);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", 32'(bus.out_valid), 1);
    chk("bp_second_tag", 32'(bus.out_tag), 4);
    idle(3);

    send(3'b111, 32'hFFFFFFFF, 32'd31, 4'h5, 0, 32'h0);
    idle(9);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    send(3'b000, 32'd1, 32'd1, 4'h6, 1, 32'h2);
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.out_valid), 1);
    idle(40);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
